// File: rtl/dma_xfer_ctrl.sv
// dma_xfer_ctrl: word-by-word copy sequencer between the DMA register block
// and two single-port memory macros (mem0 / mem1, 1-cycle read latency).
// One read and one write per 32-bit word; a sticky INTR marks completion.
// Optional feature macro: DMA_XFER_ERR_EN. It adds a sticky alignment error
// (err_o) and turns a misaligned start into an immediate DONE.
// Without the macro, low address/size bits are ignored and err_o is tied 0.

module dma_xfer_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int WADDR_LSB = 2,
    parameter int WADDR_MSB = 17,
    parameter int BANK_BIT  = 20
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              intr_clr_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [ADDR_W-1:0] size_i,
    output logic              busy_o,
    output logic              INTR,
    output logic              err_o,
    output logic              mem0_en,
    output logic [3:0]        mem0_we,
    output logic [ADDR_W-1:0] mem0_addr,
    output logic [DATA_W-1:0] mem0_wdata,
    input  logic [DATA_W-1:0] mem0_rdata,
    output logic              mem1_en,
    output logic [3:0]        mem1_we,
    output logic [ADDR_W-1:0] mem1_addr,
    output logic [DATA_W-1:0] mem1_wdata,
    input  logic [DATA_W-1:0] mem1_rdata
);

    localparam int IDX_W = WADDR_MSB - WADDR_LSB + 1;
    localparam int CNT_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_n;

    // Latched transfer context. Bank flags use the memory polarity:
    // 1 selects mem0, 0 selects mem1.
    logic [IDX_W-1:0] src_idx;
    logic [IDX_W-1:0] dst_idx;
    logic             src_bank;
    logic             dst_bank;
    logic [CNT_W-1:0] wcnt;
    logic             intr_q;

    logic [CNT_W-1:0] size_words;
    logic             start_ok;
    logic             bad_align;
    logic             unused_in_bits;

    // Bits of the address/size inputs that never reach the datapath are
    // folded together here so they are visibly intentional.
    assign unused_in_bits = ^{src_addr_i, dst_addr_i, size_i};

    assign size_words = size_i[ADDR_W-1:2];
    assign start_ok   = (state == S_IDLE) && start_i && !abort_i;
    assign busy_o     = (state != S_IDLE);
    assign INTR       = intr_q;

`ifdef DMA_XFER_ERR_EN
    logic err_q;

    assign bad_align = |{src_addr_i[1:0], dst_addr_i[1:0], size_i[1:0]};
    assign err_o     = err_q;

    // Sticky alignment error: raised when a misaligned start is accepted,
    // cleared by intr_clr_i, with a new error taking priority over a clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (start_ok && bad_align) begin
            err_q <= 1'b1;
        end else if (intr_clr_i) begin
            err_q <= 1'b0;
        end
    end
`else
    assign bad_align = 1'b0;
    assign err_o     = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic: READ/WRITE alternate until the word count runs out;
    // abort overrides every transition and returns straight to IDLE.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    if (bad_align || (size_words == '0)) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_READ;
                    end
                end
            end
            S_READ: begin
                state_n = S_WRITE;
            end
            S_WRITE: begin
                if (wcnt > CNT_W'(1)) begin
                    state_n = S_READ;
                end else begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (abort_i) begin
            state_n = S_IDLE;
        end
    end

    // Transfer context: latched on an accepted start, advanced after each
    // write. Word indices wrap inside IDX_W bits, so the bank never changes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            src_idx  <= '0;
            dst_idx  <= '0;
            src_bank <= 1'b0;
            dst_bank <= 1'b0;
            wcnt     <= '0;
        end else if (start_ok) begin
            src_idx  <= src_addr_i[WADDR_MSB:WADDR_LSB];
            dst_idx  <= dst_addr_i[WADDR_MSB:WADDR_LSB];
            src_bank <= src_addr_i[BANK_BIT];
            dst_bank <= dst_addr_i[BANK_BIT];
            wcnt     <= size_words;
        end else if (state == S_WRITE) begin
            src_idx  <= src_idx + IDX_W'(1);
            dst_idx  <= dst_idx + IDX_W'(1);
            wcnt     <= wcnt - CNT_W'(1);
        end
    end

    // Sticky completion interrupt: set by DONE unless the transfer is being
    // aborted in that cycle; a simultaneous clear loses against the set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            intr_q <= 1'b0;
        end else if ((state == S_DONE) && !abort_i) begin
            intr_q <= 1'b1;
        end else if (intr_clr_i) begin
            intr_q <= 1'b0;
        end
    end

    // Memory port drive: only the bank touched this cycle sees non-zero
    // values. Write data is the source bank's read data, which the macro
    // returns in the WRITE cycle that follows the READ.
    always_comb begin
        mem0_en    = 1'b0;
        mem0_we    = 4'h0;
        mem0_addr  = '0;
        mem0_wdata = '0;
        mem1_en    = 1'b0;
        mem1_we    = 4'h0;
        mem1_addr  = '0;
        mem1_wdata = '0;
        case (state)
            S_READ: begin
                if (src_bank) begin
                    mem0_en   = 1'b1;
                    mem0_addr = {{(ADDR_W-IDX_W){1'b0}}, src_idx};
                end else begin
                    mem1_en   = 1'b1;
                    mem1_addr = {{(ADDR_W-IDX_W){1'b0}}, src_idx};
                end
            end
            S_WRITE: begin
                if (dst_bank) begin
                    mem0_en    = 1'b1;
                    mem0_we    = 4'hF;
                    mem0_addr  = {{(ADDR_W-IDX_W){1'b0}}, dst_idx};
                    mem0_wdata = src_bank ? mem0_rdata : mem1_rdata;
                end else begin
                    mem1_en    = 1'b1;
                    mem1_we    = 4'hF;
                    mem1_addr  = {{(ADDR_W-IDX_W){1'b0}}, dst_idx};
                    mem1_wdata = src_bank ? mem0_rdata : mem1_rdata;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// tb_dma_xfer_ctrl: directed bench for dma_xfer_ctrl with two behavioural
// memory macros and a scoreboard of expected memory accesses.

module tb_dma_xfer_ctrl;

    logic        CLK;
    logic        RST;
    logic        start_i;
    logic        abort_i;
    logic        intr_clr_i;
    logic [31:0] src_addr_i;
    logic [31:0] dst_addr_i;
    logic [31:0] size_i;
    logic        busy_o;
    logic        INTR;
    logic        err_o;
    logic        mem0_en;
    logic [3:0]  mem0_we;
    logic [31:0] mem0_addr;
    logic [31:0] mem0_wdata;
    logic [31:0] mem0_rdata;
    logic        mem1_en;
    logic [3:0]  mem1_we;
    logic [31:0] mem1_addr;
    logic [31:0] mem1_wdata;
    logic [31:0] mem1_rdata;

    typedef struct {
        logic        rd;
        logic        bank;
        logic [15:0] idx;
        logic [31:0] data;
    } acc_t;

    acc_t        exp_q[$];
    int          checks;
    int          failures;
    int          writes_seen;
    int          cyc;
    int          wr_before;
    logic [31:0] m0 [0:65535];
    logic [31:0] m1 [0:65535];

    dma_xfer_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .intr_clr_i (intr_clr_i),
        .src_addr_i (src_addr_i),
        .dst_addr_i (dst_addr_i),
        .size_i     (size_i),
        .busy_o     (busy_o),
        .INTR       (INTR),
        .err_o      (err_o),
        .mem0_en    (mem0_en),
        .mem0_we    (mem0_we),
        .mem0_addr  (mem0_addr),
        .mem0_wdata (mem0_wdata),
        .mem0_rdata (mem0_rdata),
        .mem1_en    (mem1_en),
        .mem1_we    (mem1_we),
        .mem1_addr  (mem1_addr),
        .mem1_wdata (mem1_wdata),
        .mem1_rdata (mem1_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Initial memory content: bank tag in the upper half, word index below.
    function automatic logic [31:0] pat(input logic bank, input logic [15:0] idx);
        return {(bank ? 16'hC0DE : 16'hBEEF), idx};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_rd(input logic bank, input logic [15:0] idx);
        acc_t e;
        e.rd = 1'b1; e.bank = bank; e.idx = idx; e.data = 32'h0;
        exp_q.push_back(e);
    endtask

    task automatic push_wr(input logic bank, input logic [15:0] idx, input logic [31:0] data);
        acc_t e;
        e.rd = 1'b0; e.bank = bank; e.idx = idx; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push_copy(input logic sb, input logic [15:0] sidx,
                             input logic db, input logic [15:0] didx, input int n);
        for (int i = 0; i < n; i++) begin
            push_rd(sb, sidx + 16'(i));
            push_wr(db, didx + 16'(i), pat(sb, sidx + 16'(i)));
        end
    endtask

    // Drive one start pulse in the current cycle; returns in cycle 1.
    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] size);
        src_addr_i = src;
        dst_addr_i = dst;
        size_i     = size;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
    endtask

    // Count cycles (from cycle 1) until INTR shows, bounded.
    task automatic wait_intr(output int n);
        n = 1;
        while (!INTR && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic clear_intr();
        intr_clr_i = 1'b1;
        tick();
        intr_clr_i = 1'b0;
        checkOutput("intr_cleared", 32'(INTR), 32'd0);
    endtask

    // Behavioural memory macros with 1-cycle read latency.
    always @(posedge CLK) begin
        if (mem0_en) begin
            if (mem0_we != 4'h0) m0[mem0_addr[15:0]] <= mem0_wdata;
            else                 mem0_rdata <= m0[mem0_addr[15:0]];
        end
        if (mem1_en) begin
            if (mem1_we != 4'h0) m1[mem1_addr[15:0]] <= mem1_wdata;
            else                 mem1_rdata <= m1[mem1_addr[15:0]];
        end
    end

    // Access monitor: every enabled cycle must match the scoreboard head,
    // and the idle bank must present all-zero outputs.
    always @(negedge CLK) begin
        acc_t        e;
        logic [3:0]  we;
        logic [31:0] ad;
        logic [31:0] wd;
        if (mem0_en || mem1_en) begin
            checkOutput("single_bank", 32'(mem0_en & mem1_en), 32'd0);
            checkOutput("access_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                we = mem0_en ? mem0_we : mem1_we;
                ad = mem0_en ? mem0_addr : mem1_addr;
                wd = mem0_en ? mem0_wdata : mem1_wdata;
                checkOutput("acc_bank", 32'(mem0_en), 32'(e.bank));
                checkOutput("acc_we", 32'(we), e.rd ? 32'h0 : 32'hF);
                checkOutput("acc_addr", ad, {16'h0, e.idx});
                checkOutput("acc_wdata", wd, e.data);
                if (!e.rd) writes_seen++;
            end
        end
        if (!mem0_en) checkOutput("mem0_idle", 32'(mem0_we == 4'h0 && mem0_addr == 32'h0 && mem0_wdata == 32'h0), 32'd1);
        if (!mem1_en) checkOutput("mem1_idle", 32'(mem1_we == 4'h0 && mem1_addr == 32'h0 && mem1_wdata == 32'h0), 32'd1);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        writes_seen = 0;
        for (int i = 0; i < 65536; i++) begin
            m0[i] = pat(1'b1, 16'(i));
            m1[i] = pat(1'b0, 16'(i));
        end
        mem0_rdata = 32'h0;
        mem1_rdata = 32'h0;
        RST        = 1'b1;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        intr_clr_i = 1'b0;
        src_addr_i = 32'h0;
        dst_addr_i = 32'h0;
        size_i     = 32'h0;

        // Reset values
        tick(); tick(); tick();
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_intr", 32'(INTR), 32'd0);
        checkOutput("rst_err", 32'(err_o), 32'd0);
        checkOutput("rst_mem_en", 32'({mem0_en, mem1_en}), 32'd0);
        RST = 1'b0;
        tick();

        // 4-word copy mem0[0..3] -> mem1[0x10..0x13], INTR in cycle 10
        push_copy(1'b1, 16'h0000, 1'b0, 16'h0010, 4);
        applyStimulus(32'h0010_0000, 32'h0000_0040, 32'd16);
        checkOutput("t1_busy_c1", 32'(busy_o), 32'd1);
        wait_intr(cyc);
        checkOutput("t1_intr_cycle", 32'(cyc), 32'd10);
        checkOutput("t1_busy_end", 32'(busy_o), 32'd0);
        checkOutput("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        tick(); tick();
        checkOutput("t1_intr_sticky", 32'(INTR), 32'd1);

        // size=0 while INTR=1, clear held through DONE: set wins
        intr_clr_i = 1'b1;
        applyStimulus(32'h0010_0000, 32'h0000_0040, 32'd0);
        checkOutput("t2_busy_c1", 32'(busy_o), 32'd1);
        checkOutput("t2_intr_c1", 32'(INTR), 32'd0);
        tick();
        intr_clr_i = 1'b0;
        checkOutput("t2_intr_c2", 32'(INTR), 32'd1);
        checkOutput("t2_busy_c2", 32'(busy_o), 32'd0);
        checkOutput("t2_no_access", 32'(exp_q.size()), 32'd0);
        clear_intr();

        // Same-bank copy mem0[0..1] -> mem0[0x40..0x41]
        push_copy(1'b1, 16'h0000, 1'b1, 16'h0040, 2);
        applyStimulus(32'h0010_0000, 32'h0010_0100, 32'd8);
        wait_intr(cyc);
        checkOutput("t3_intr_cycle", 32'(cyc), 32'd6);
        checkOutput("t3_queue_empty", 32'(exp_q.size()), 32'd0);
        clear_intr();

        // Abort after the 2nd write of an 8-word copy
        wr_before = writes_seen;
        push_copy(1'b1, 16'h0100, 1'b0, 16'h0200, 2);
        push_rd(1'b1, 16'h0102);
        applyStimulus(32'h0010_0400, 32'h0000_0800, 32'd32);
        tick(); tick(); tick(); tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        checkOutput("t4_busy_after_abort", 32'(busy_o), 32'd0);
        tick(); tick(); tick();
        checkOutput("t4_intr_low", 32'(INTR), 32'd0);
        checkOutput("t4_words_written", 32'(writes_seen - wr_before), 32'd2);
        checkOutput("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // abort and start together in IDLE: stay IDLE
        abort_i = 1'b1;
        applyStimulus(32'h0010_0000, 32'h0000_0040, 32'd16);
        abort_i = 1'b0;
        checkOutput("t5_busy", 32'(busy_o), 32'd0);
        tick();
        checkOutput("t5_intr", 32'(INTR), 32'd0);

        // Source word index wraps 0xFFFF -> 0x0000 inside mem0
        push_copy(1'b1, 16'hFFFF, 1'b0, 16'h0300, 2);
        applyStimulus(32'h0013_FFFC, 32'h0000_0C00, 32'd8);
        wait_intr(cyc);
        checkOutput("t6_intr_cycle", 32'(cyc), 32'd6);
        checkOutput("t6_queue_empty", 32'(exp_q.size()), 32'd0);
        clear_intr();

        // Misaligned source address
`ifdef DMA_XFER_ERR_EN
        applyStimulus(32'h0010_0002, 32'h0000_1000, 32'd4);
        wait_intr(cyc);
        checkOutput("t7_intr_cycle", 32'(cyc), 32'd2);
        checkOutput("t7_err", 32'(err_o), 32'd1);
        checkOutput("t7_no_access", 32'(exp_q.size()), 32'd0);
        clear_intr();
        checkOutput("t7_err_cleared", 32'(err_o), 32'd0);
`else
        push_copy(1'b1, 16'h0000, 1'b0, 16'h0400, 1);
        applyStimulus(32'h0010_0002, 32'h0000_1000, 32'd4);
        wait_intr(cyc);
        checkOutput("t7_intr_cycle", 32'(cyc), 32'd4);
        checkOutput("t7_err_tied", 32'(err_o), 32'd0);
        checkOutput("t7_queue_empty", 32'(exp_q.size()), 32'd0);
        clear_intr();
`endif

        // Reset in the middle of a transfer
        push_copy(1'b1, 16'h0500, 1'b0, 16'h0600, 1);
        push_rd(1'b1, 16'h0501);
        applyStimulus(32'h0010_1400, 32'h0000_1800, 32'd16);
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("t8_busy", 32'(busy_o), 32'd0);
        tick(); tick(); tick();
        checkOutput("t8_intr", 32'(INTR), 32'd0);
        checkOutput("t8_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
